ntsc_composite_enc: RTL and testbench



---
 rtl/ntsc_pkg.sv | 28 ++
 rtl/ntsc_chroma_mod.sv | 33 +++
 rtl/ntsc_composite_enc.sv | 147 ++++++++++++++
 tb/tb_ntsc_composite_enc.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntsc_pkg.sv
// Shared definitions for the composite encoders: line-state enum, subcarrier sine table,
// and default sync/burst/level constants.
package ntsc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_BREEZE,
        ST_BURST,
        ST_BACK,
        ST_ACTIVE
    } line_state_t;

    localparam int DEF_SYNC_LEN    = 269;
    localparam int DEF_BREEZE_LEN  = 34;
    localparam int DEF_BURST_LEN   = 144;
    localparam int DEF_BACK_LEN    = 91;
    localparam int DEF_BLANK_LVL   = 60;
    localparam int DEF_BURST_AMP   = 6;
    localparam int DEF_BURST_PHASE = 8;

    // One subcarrier period sampled at 16 points, amplitude 15.
    localparam logic signed [4:0] SIN16 [16] = '{
        5'sd0,   5'sd6,   5'sd11,  5'sd14,  5'sd15,  5'sd14,  5'sd11,  5'sd6,
        5'sd0,  -5'sd6,  -5'sd11, -5'sd14, -5'sd15, -5'sd14, -5'sd11, -5'sd6
    };

endpackage

// File: rtl/ntsc_chroma_mod.sv
// Chroma modulator: registers phase index and amplitude, then registers
// (amp * sin[idx]) >>> 2. Two cycles from inputs to chroma.
module ntsc_chroma_mod
    import ntsc_pkg::*;
(
    input  logic               clk,
    input  logic [3:0]         idx,
    input  logic [3:0]         amp,
    output logic signed [7:0]  chroma
);

    logic [3:0]        idx_p0;
    logic [3:0]        amp_p0;
    logic signed [9:0] prod_p0;

    function automatic logic signed [7:0] scale_q2(input logic signed [9:0] p);
        return 8'(p >>> 2);
    endfunction

    // Stage 1: capture phase index and amplitude
    always_ff @(posedge clk) begin
        idx_p0 <= idx;
        amp_p0 <= amp;
    end

    assign prod_p0 = 10'($signed({1'b0, amp_p0})) * 10'(SIN16[idx_p0]);

    // Stage 2: scaled product; the arithmetic shift floors toward -inf
    always_ff @(posedge clk) begin
        chroma <= scale_q2(prod_p0);
    end

endmodule

// File: rtl/ntsc_composite_enc.sv
// NTSC composite encoder on the 16x subcarrier clock: line sequencer plus 3-stage mixer.
// Define NTSC_CHROMA_EN to build the chroma modulator and colour burst; otherwise monochrome.
module ntsc_composite_enc
    import ntsc_pkg::*;
#(
    parameter int SYNC_LEN    = DEF_SYNC_LEN,
    parameter int BREEZE_LEN  = DEF_BREEZE_LEN,
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int BACK_LEN    = DEF_BACK_LEN,
    parameter int BLANK_LVL   = DEF_BLANK_LVL,
    parameter int BURST_AMP   = DEF_BURST_AMP,
    parameter int BURST_PHASE = DEF_BURST_PHASE
) (
    input  logic       clk_col16x,
    input  logic       reset,
    input  logic       hsync,
    input  logic       video_active,
    input  logic [5:0] luma,
    input  logic [3:0] hue,
    input  logic [3:0] amp,
    output logic [7:0] composite,
    output logic       burst_gate
);

    line_state_t state;
    logic [9:0]  cnt;
    logic [3:0]  phase_ctr;

    // Line sequencer; hsync overrides every other transition
    always_ff @(posedge clk_col16x) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            phase_ctr <= '0;
        end else begin
            phase_ctr <= phase_ctr + 4'd1;
            if (hsync) begin
                state <= ST_SYNC;
                cnt   <= 10'(SYNC_LEN - 1);
            end else if (cnt != '0) begin
                cnt <= cnt - 10'd1;
            end else begin
                case (state)
                    ST_SYNC:   begin state <= ST_BREEZE; cnt <= 10'(BREEZE_LEN - 1); end
                    ST_BREEZE: begin state <= ST_BURST;  cnt <= 10'(BURST_LEN - 1);  end
                    ST_BURST:  begin state <= ST_BACK;   cnt <= 10'(BACK_LEN - 1);   end
                    ST_BACK:   begin state <= ST_ACTIVE; cnt <= '0;                  end
                    default:   ;
                endcase
            end
        end
    end

    line_state_t       st_p0, st_p1;
    logic              vld_p0, vld_p1;
    logic [5:0]        luma_p0, luma_p1;
    logic signed [7:0] chroma_p1;
    logic              burst_en;

    // Stage 1 / stage 2 control and luma, alongside the chroma modulator
    always_ff @(posedge clk_col16x) begin
        if (reset) begin
            st_p0  <= ST_IDLE;
            st_p1  <= ST_IDLE;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            st_p0  <= state;
            st_p1  <= st_p0;
            vld_p0 <= video_active;
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk_col16x) begin
        luma_p0 <= luma;
        luma_p1 <= luma_p0;
    end

`ifdef NTSC_CHROMA_EN
    logic [3:0] chroma_idx;
    logic [3:0] chroma_amp;

    // Zero amplitude outside burst/active video makes the chroma term vanish
    always_comb begin
        chroma_idx = phase_ctr + hue;
        chroma_amp = '0;
        if (state == ST_BURST) begin
            chroma_idx = phase_ctr + 4'(BURST_PHASE);
            chroma_amp = 4'(BURST_AMP);
        end else if (state == ST_ACTIVE && video_active) begin
            chroma_amp = amp;
        end
    end

    ntsc_chroma_mod u_chroma (
        .clk    (clk_col16x),
        .idx    (chroma_idx),
        .amp    (chroma_amp),
        .chroma (chroma_p1)
    );

    assign burst_en = 1'b1;
`else
    logic unused_chroma_in;
    assign unused_chroma_in = ^{hue, amp, phase_ctr, 4'(BURST_AMP), 4'(BURST_PHASE)};
    assign chroma_p1        = '0;
    assign burst_en         = 1'b0;
`endif

    function automatic logic [7:0] clamp_u8(input logic signed [9:0] v);
        if (v < 10'sd0)
            return 8'd0;
        else if (v > 10'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    logic signed [9:0] blank_s, luma_s, chroma_s, sum_p1;

    assign blank_s  = 10'(BLANK_LVL);
    assign luma_s   = $signed({3'b000, luma_p1, 1'b0});
    assign chroma_s = {{2{chroma_p1[7]}}, chroma_p1};

    always_comb begin
        sum_p1 = blank_s;
        case (st_p1)
            ST_SYNC:   sum_p1 = '0;
            ST_BURST:  sum_p1 = blank_s + chroma_s;
            ST_ACTIVE: if (vld_p1) sum_p1 = blank_s + luma_s + chroma_s;
            default:   ;
        endcase
    end

    // Stage 3: clamp and register the DAC sample
    always_ff @(posedge clk_col16x) begin
        if (reset) begin
            composite  <= 8'(BLANK_LVL);
            burst_gate <= 1'b0;
        end else begin
            composite  <= clamp_u8(sum_p1);
            burst_gate <= burst_en && (st_p1 == ST_BURST);
        end
    end

endmodule

// File: tb/tb_ntsc_composite_enc.sv
// Directed bench for ntsc_composite_enc: reset, line timing, burst/active mixing, clamps,
// hsync restarts and mid-line reset. Expectations follow NTSC_CHROMA_EN when defined.
module tb_ntsc_composite_enc;

`ifdef NTSC_CHROMA_EN
    localparam bit CHR = 1'b1;
`else
    localparam bit CHR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, hsync, video_active;
    logic [5:0] luma;
    logic [3:0] hue, amp;
    logic [7:0] composite, composite_lo, composite_hi;
    logic       burst_gate, burst_gate_lo, burst_gate_hi;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] ph;

    // Burst composite (BLANK 60, amp 6, +180 deg) by phase of the originating cycle
    int burst_tab [16] = '{60, 51, 43, 39, 37, 39, 43, 51, 60, 69, 76, 81, 82, 81, 76, 69};
    // Chroma term for amp=15, hue=4 by phase of the originating cycle
    int chr_tab   [16] = '{56, 52, 41, 22, 0, -23, -42, -53, -57, -53, -42, -23, 0, 22, 41, 52};

    ntsc_composite_enc dut (
        .clk_col16x(clk), .reset(reset), .hsync(hsync), .video_active(video_active),
        .luma(luma), .hue(hue), .amp(amp), .composite(composite), .burst_gate(burst_gate)
    );

    ntsc_composite_enc #(.BLANK_LVL(0)) dut_lo (
        .clk_col16x(clk), .reset(reset), .hsync(hsync), .video_active(video_active),
        .luma(luma), .hue(hue), .amp(amp), .composite(composite_lo), .burst_gate(burst_gate_lo)
    );

    ntsc_composite_enc #(.BLANK_LVL(200)) dut_hi (
        .clk_col16x(clk), .reset(reset), .hsync(hsync), .video_active(video_active),
        .luma(luma), .hue(hue), .amp(amp), .composite(composite_hi), .burst_gate(burst_gate_hi)
    );

    task automatic step();
        @(posedge clk);
        if (reset) ph = 4'd0;
        else       ph = ph + 4'd1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; hsync = 1'b1; video_active = 1'b0; luma = '0; hue = '0; amp = '0;
        repeat (4) step();
        n_checks += 3;
        if (composite !== 8'd60) begin
            n_fail++; $display("FAIL reset_composite got %0d expected 60", composite);
        end
        if (composite_lo !== 8'd0 || composite_hi !== 8'd200) begin
            n_fail++; $display("FAIL reset_override got %0d/%0d expected 0/200", composite_lo, composite_hi);
        end
        if (burst_gate !== 1'b0) begin
            n_fail++; $display("FAIL reset_burst_gate got %b expected 0", burst_gate);
        end
        reset = 1'b0; hsync = 1'b0;
        for (int i = 0; i < 40; i++) begin
            n_checks++;
            if (composite !== 8'd60 || burst_gate !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_reset cycle %0d got %0d/%b expected 60/0", i, composite, burst_gate);
            end
            step();
        end
    endtask

    task automatic test_line();
        logic [3:0] sp;
        int   exp_c;
        logic exp_b;
        video_active = 1'b0; luma = '0; hue = '0; amp = '0;
        hsync = 1'b1; step(); hsync = 1'b0;
        for (int k = 1; k <= 545; k++) begin
            sp = ph - 4'd3;
            exp_c = 60; exp_b = 1'b0;
            if (k >= 4 && k <= 272) exp_c = 0;
            else if (k >= 307 && k <= 450) begin
                exp_c = CHR ? burst_tab[sp] : 60;
                exp_b = CHR;
            end
            n_checks++;
            if (composite !== 8'(exp_c) || burst_gate !== exp_b) begin
                n_fail++;
                $display("FAIL line_timing k=%0d got %0d/%b expected %0d/%b", k, composite, burst_gate, exp_c, exp_b);
            end
            if (k < 545) step();
        end
    endtask

    task automatic test_active_mix();
        logic [3:0] sp;
        int c, e_main, e_lo, e_hi;
        video_active = 1'b1; luma = 6'd63; hue = 4'd4; amp = 4'd15;
        repeat (3) step();
        for (int i = 0; i < 16; i++) begin
            sp = ph - 4'd3;
            c = CHR ? chr_tab[sp] : 0;
            e_main = 186 + c; e_lo = 126 + c; e_hi = 255;
            n_checks++;
            if (composite !== 8'(e_main) || composite_lo !== 8'(e_lo) || composite_hi !== 8'(e_hi)) begin
                n_fail++;
                $display("FAIL active_luma63 phase %0d got %0d/%0d/%0d expected %0d/%0d/%0d",
                         sp, composite, composite_lo, composite_hi, e_main, e_lo, e_hi);
            end
            step();
        end
        luma = 6'd0;
        repeat (3) step();
        for (int i = 0; i < 16; i++) begin
            sp = ph - 4'd3;
            c = CHR ? chr_tab[sp] : 0;
            e_main = 60 + c;
            e_lo = (c < 0) ? 0 : c;
            e_hi = (200 + c > 255) ? 255 : 200 + c;
            n_checks++;
            if (composite !== 8'(e_main) || composite_lo !== 8'(e_lo) || composite_hi !== 8'(e_hi)) begin
                n_fail++;
                $display("FAIL active_luma0 phase %0d got %0d/%0d/%0d expected %0d/%0d/%0d",
                         sp, composite, composite_lo, composite_hi, e_main, e_lo, e_hi);
            end
            step();
        end
    endtask

    task automatic test_hsync_mid_burst();
        logic [3:0] sp;
        int   exp_c;
        logic exp_b;
        video_active = 1'b0; luma = '0; hue = '0; amp = '0;
        hsync = 1'b1; step(); hsync = 1'b0;
        repeat (349) step();
        hsync = 1'b1; step(); hsync = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            sp = ph - 4'd3;
            exp_c = (k < 4) ? (CHR ? burst_tab[sp] : 60) : 0;
            exp_b = (k < 4) ? CHR : 1'b0;
            n_checks++;
            if (composite !== 8'(exp_c) || burst_gate !== exp_b) begin
                n_fail++;
                $display("FAIL hsync_mid_burst k=%0d got %0d/%b expected %0d/%b", k, composite, burst_gate, exp_c, exp_b);
            end
            if (k < 12) step();
        end
    endtask

    task automatic test_hsync_mid_active();
        int exp_c;
        repeat (528) step();
        video_active = 1'b1; luma = 6'd32; hue = 4'd0; amp = 4'd0;
        repeat (16) step();
        for (int k = 556; k <= 560; k++) begin
            n_checks++;
            if (composite !== 8'd124) begin
                n_fail++; $display("FAIL active_flat k=%0d got %0d expected 124", k, composite);
            end
            if (k < 560) step();
        end
        hsync = 1'b1; step(); hsync = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            exp_c = (k < 4) ? 124 : 0;
            n_checks++;
            if (composite !== 8'(exp_c) || burst_gate !== 1'b0) begin
                n_fail++;
                $display("FAIL hsync_mid_active k=%0d got %0d/%b expected %0d/0", k, composite, burst_gate, exp_c);
            end
            if (k < 10) step();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] sp;
        int   exp_c;
        logic exp_b;
        video_active = 1'b0; luma = '0;
        hsync = 1'b1; step(); step(); hsync = 1'b0;
        for (int k = 2; k <= 312; k++) begin
            sp = ph - 4'd3;
            exp_c = 60; exp_b = 1'b0;
            if (k <= 273) exp_c = 0;
            else if (k >= 308) begin
                exp_c = CHR ? burst_tab[sp] : 60;
                exp_b = CHR;
            end
            n_checks++;
            if (composite !== 8'(exp_c) || burst_gate !== exp_b) begin
                n_fail++;
                $display("FAIL back_to_back k=%0d got %0d/%b expected %0d/%b", k, composite, burst_gate, exp_c, exp_b);
            end
            if (k < 312) step();
        end
    endtask

    task automatic test_reset_mid_line();
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (composite !== 8'd60 || burst_gate !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flush cycle %0d got %0d/%b expected 60/0", i, composite, burst_gate);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_active_mix();
        test_hsync_mid_burst();
        test_hsync_mid_active();
        test_back_to_back();
        test_reset_mid_line();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
